// File: rtl/sa_param_fifo.sv
// sa_param_fifo: parametrised {addr,data} FIFO for systolic-array stages.
// Ports: clk/rstn, wr_en/wr_addr/wr_data, rd_en -> rd_addr/rd_data/rd_valid,
//   empty/full/almost_empty/almost_full/count, sticky overflow/underflow
//   with err_clr.
// Macro SA_FIFO_FWFT_EN: first-word fall-through read; undefined gives a
//   registered 1-cycle read.
module sa_param_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_af_chk
    $error("sa_param_fifo: AF_THRESH out of range 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_ae_chk
    $error("sa_param_fifo: AE_THRESH out of range 0..DEPTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_dp_chk
    $error("sa_param_fifo: DEPTH must be a power of two >= 2");
  end

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [PTR_W-1:0] cnt;
  logic             wr_acc, rd_acc;

  always_comb begin
    wr_idx = wr_ptr_q[IDX_W-1:0];
    rd_idx = rd_ptr_q[IDX_W-1:0];
    cnt    = wr_ptr_q - rd_ptr_q;
    empty  = (wr_ptr_q == rd_ptr_q);
    // same slot, opposite lap
    full   = (wr_idx == rd_idx) &&
             (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    almost_full  = (cnt >= AF_T);
    almost_empty = (cnt <= AE_T);
    count        = cnt;
    overflow     = ovf_q;
    underflow    = unf_q;
    // a read frees the head slot, so a full FIFO can still take a write
    wr_acc = wr_en && (!full || rd_en);
    rd_acc = rd_en && !empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
    // a fresh error beats a concurrent clear
    ovf_d = (ovf_q && !err_clr) || (wr_en && full && !rd_en);
    unf_d = (unf_q && !err_clr) || (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // storage is not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx] <= {wr_addr, wr_data};
  end

`ifdef SA_FIFO_FWFT_EN
  always_comb begin
    rd_addr  = mem_q[rd_idx][ENT_W-1:DATA_W];
    rd_data  = mem_q[rd_idx][DATA_W-1:0];
    rd_valid = !empty;
  end
`else
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      rd_addr_d = mem_q[rd_idx][ENT_W-1:DATA_W];
      rd_data_d = mem_q[rd_idx][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    rd_addr  = rd_addr_q;
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
  end
`endif

endmodule

// File: tb/tb_sa_param_fifo.sv
// tb_sa_param_fifo: randomized + directed bench for sa_param_fifo
// against a queue-based reference model (both read modes).
module tb_sa_param_fifo;

  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en, rd_en, err_clr;
  logic [7:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, empty, full;
  logic        almost_empty, almost_full;
  logic [3:0]  count;
  logic        overflow, underflow;

  sa_param_fifo #(
    .DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH),
    .AF_THRESH(AFT), .AE_THRESH(AET)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] q[$];
  logic [23:0] exp_rd, obs_rd, tmp;
  bit          exp_v, obs_v, exp_ovf, exp_unf;

  // drive one cycle; update the model; capture the read port
  task automatic step(input bit w, input logic [7:0] a,
                      input logic [15:0] d, input bit r,
                      input bit c);
    int n;
    n = q.size();
    wr_en = w; wr_addr = a; wr_data = d;
    rd_en = r; err_clr = c;
    exp_rd = (n > 0) ? q[0] : 24'h0;
`ifdef SA_FIFO_FWFT_EN
    exp_v = (n > 0);
    #1;
    obs_v  = rd_valid;
    obs_rd = {rd_addr, rd_data};
`else
    exp_v = r && (n > 0);
`endif
    exp_ovf = (exp_ovf && !c) || (w && n == DEPTH && !r);
    exp_unf = (exp_unf && !c) || (r && n == 0);
    if (r && n > 0) tmp = q.pop_front();
    if (w && (n < DEPTH || r)) q.push_back({a, d});
    @(posedge clk); #1;
`ifndef SA_FIFO_FWFT_EN
    obs_v  = rd_valid;
    obs_rd = {rd_addr, rd_data};
`endif
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++)
      step(0, 0, 0, 1, 0);
  endtask

  task automatic model_reset();
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=1100",
               {empty, almost_empty, full, almost_full});
    end
    total++;
    if ({count, rd_valid, overflow, underflow} !== 7'd0) begin
      bad++;
      $display("FAIL rst_state cnt=%0d v=%b o=%b u=%b exp=0",
               count, rd_valid, overflow, underflow);
    end
`ifndef SA_FIFO_FWFT_EN
    total++;
    if ({rd_addr, rd_data} !== 24'h0) begin
      bad++;
      $display("FAIL rst_rdout got=%h exp=0", {rd_addr, rd_data});
    end
`endif
    for (int i = 0; i < 5; i++)
      step(1, 8'(i + 100), 16'(i), 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 8'd105, 16'd5, 0, 0);
    total++;
    if (count !== 4'd5) begin
      bad++;
      $display("FAIL rst_pre_cnt got=%0d exp=5", count);
    end
    // reset mid-cycle with traffic pending
    wr_en = 1'b1; rd_en = 1'b1; wr_addr = 8'h55;
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({empty, almost_empty, full, almost_full, rd_valid} !== 5'b11000)
    begin
      bad++;
      $display("FAIL rst_async_flags got=%b exp=11000",
               {empty, almost_empty, full, almost_full, rd_valid});
    end
    total++;
    if ({count, overflow, underflow} !== 6'd0) begin
      bad++;
      $display("FAIL rst_async_cnt cnt=%0d o=%b u=%b exp=0",
               count, overflow, underflow);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 16'(i), 0, 0);
      total++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= AFT) ||
          full !== (i + 1 == DEPTH)) begin
        bad++;
        $display("FAIL fill_%0d cnt=%0d af=%b f=%b exp cnt=%0d",
                 i, count, almost_full, full, i + 1);
      end
    end
    step(1, 8'd8, 16'd8, 0, 0);
    total++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      bad++;
      $display("FAIL fill_ovf o=%b cnt=%0d f=%b exp 1/8/1",
               overflow, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 1, 0);
      total++;
      if (obs_v !== 1'b1 || obs_rd !== {8'(i), 16'(i)}) begin
        bad++;
        $display("FAIL drain_%0d v=%b got=%h exp=%h",
                 i, obs_v, obs_rd, {8'(i), 16'(i)});
      end
      total++;
      if (count !== 4'(DEPTH - 1 - i) ||
          almost_empty !== (DEPTH - 1 - i <= AET) ||
          empty !== (i == DEPTH - 1)) begin
        bad++;
        $display("FAIL drain_cnt_%0d cnt=%0d ae=%b e=%b",
                 i, count, almost_empty, empty);
      end
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || obs_v !== 1'b0) begin
      bad++;
      $display("FAIL drain_unf u=%b v=%b exp u=1 v=0",
               underflow, rd_valid);
    end
  endtask

  task automatic test_full_rdwr();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++)
      step(1, 8'(40 + i), 16'($urandom), 0, 0);
    step(1, 8'd20, 16'h2020, 1, 0);
    total++;
    if (obs_v !== 1'b1 || obs_rd[23:16] !== 8'd40) begin
      bad++;
      $display("FAIL fullrw_head v=%b got=%0d exp=40",
               obs_v, obs_rd[23:16]);
    end
    total++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL fullrw_flags cnt=%0d f=%b o=%b exp 8/1/0",
               count, full, overflow);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
    total++;
    if (obs_rd !== {8'd20, 16'h2020}) begin
      bad++;
      $display("FAIL fullrw_last got=%h exp=142020", obs_rd);
    end
  endtask

  task automatic test_empty_rdwr();
    step(0, 0, 0, 0, 1);
    step(1, 8'd30, 16'h0030, 1, 0);
    total++;
    if (underflow !== 1'b1 || count !== 4'd1) begin
      bad++;
      $display("FAIL emptyrw u=%b cnt=%0d exp 1/1", underflow, count);
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (obs_v !== 1'b1 || obs_rd !== {8'd30, 16'h0030}) begin
      bad++;
      $display("FAIL emptyrw_rd v=%b got=%h exp=1e0030", obs_v, obs_rd);
    end
  endtask

  task automatic test_wrap_errclr();
    int errs;
    drain_all();
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 16'($urandom), 0, 0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom), 16'($urandom), 1, 0);
      if (obs_v !== 1'b1 || obs_rd !== exp_rd || count !== 4'd3)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap errs=%0d exp=0", errs);
    end
    drain_all();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 16'(i), 0, 0);
    step(0, 0, 0, 0, 1);
    total++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL errclr o=%b u=%b exp 0/0", overflow, underflow);
    end
    step(1, 8'd9, 16'd9, 0, 1);
    total++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      bad++;
      $display("FAIL errclr_win o=%b cnt=%0d exp 1/8", overflow, count);
    end
    drain_all();
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 6);
      step(w, 8'($urandom), 16'($urandom), r, c);
      total++;
      if (count !== 4'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) ||
          almost_full !== (q.size() >= AFT) ||
          almost_empty !== (q.size() <= AET)) begin
        bad++;
        $display("FAIL rnd_flags_%0d cnt=%0d exp=%0d e=%b f=%b",
                 i, count, q.size(), empty, full);
      end
      total++;
      if (overflow !== exp_ovf || underflow !== exp_unf) begin
        bad++;
        $display("FAIL rnd_err_%0d o=%b u=%b exp o=%b u=%b",
                 i, overflow, underflow, exp_ovf, exp_unf);
      end
      total++;
      if (obs_v !== exp_v || (exp_v && obs_rd !== exp_rd)) begin
        bad++;
        $display("FAIL rnd_rd_%0d v=%b got=%h exp v=%b d=%h",
                 i, obs_v, obs_rd, exp_v, exp_rd);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wr_addr = '0; wr_data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_full_rdwr();
    test_empty_rdwr();
    test_wrap_errclr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
